// File: rtl/q_run_logger_if.sv
// Record drain handshake between q_run_logger and its consumer.
interface q_run_logger_if #(
    parameter int unsigned CNT_W = 8
);
    logic             rec_valid;
    logic             rec_ready;
    logic [CNT_W-1:0] rec_len;
    logic             rec_sat;

    modport master (
        output rec_valid,
        output rec_len,
        output rec_sat,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_len,
        input  rec_sat,
        output rec_ready
    );
endinterface

// File: rtl/q_run_logger.sv
// q_run_logger: measures high runs of the detector output q (sampled on smp),
// queues each completed run as {sat,len} in a small FIFO drained via
// valid/ready, and keeps a saturating count of completed runs.
// Optional feature macro: Q_RUNLOG_DROP_CNT_EN adds a saturating drop_cnt port
// counting records lost to a full FIFO.
module q_run_logger #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TOT_W = 16
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              q_in,
    input  logic              smp,
    q_run_logger_if.master    rec,
    output logic [TOT_W-1:0]  ev_count,
    output logic              busy,
    output logic              fifo_full
`ifdef Q_RUNLOG_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]  drop_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [CNT_W-1:0] LEN_MAX = {CNT_W{1'b1}};
    localparam logic [TOT_W-1:0] EV_MAX  = {TOT_W{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic             sat;
        logic [CNT_W-1:0] len;
    } rec_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             sat_q, sat_d;
    logic             push_c;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [TOT_W-1:0] ev_count_q, ev_count_d;
    rec_t             mem_q [DEPTH];

    logic             empty_c;
    logic             full_c;
    logic             pop_c;
    logic             push_ok_c;
    rec_t             head_c;

    // Run-tracking FSM: next state, run length and saturation flag.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sat_d   = sat_q;
        push_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (smp && q_in) begin
                    state_d = RUN;
                    len_d   = CNT_W'(1);
                    sat_d   = 1'b0;
                end
            end
            RUN: begin
                if (smp) begin
                    if (q_in) begin
                        if (len_q == LEN_MAX) begin
                            sat_d = 1'b1;
                        end else begin
                            len_d = len_q + CNT_W'(1);
                        end
                    end else begin
                        push_c  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO status; a full FIFO still accepts a push when the head is popped in the same cycle.
    always_comb begin
        empty_c    = (wr_ptr_q == rd_ptr_q);
        full_c     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_c      = !empty_c && rec.rec_ready;
        push_ok_c  = push_c && (!full_c || pop_c);
        wr_ptr_d   = wr_ptr_q + PW'(push_ok_c);
        rd_ptr_d   = rd_ptr_q + PW'(pop_c);
        ev_count_d = ev_count_q;
        if (push_c && (ev_count_q != EV_MAX)) begin
            ev_count_d = ev_count_q + TOT_W'(1);
        end
    end

    // State, pointer and counter registers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            sat_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ev_count_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sat_q      <= sat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ev_count_q <= ev_count_d;
        end
    end

    // Record storage; contents are only visible through a valid head, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= rec_t'{sat: sat_q, len: len_q};
        end
    end

`ifdef Q_RUNLOG_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             drop_c;

    // Saturating count of records lost to a full FIFO.
    always_comb begin
        drop_c     = push_c && full_c && !pop_c;
        drop_cnt_d = drop_cnt_q;
        if (drop_c && (drop_cnt_q != LEN_MAX)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    // Head record forced to zero while the FIFO is empty.
    always_comb begin
        head_c = '0;
        if (!empty_c) begin
            head_c = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    assign rec.rec_valid = !empty_c;
    assign rec.rec_len   = head_c.len;
    assign rec.rec_sat   = head_c.sat;
    assign ev_count      = ev_count_q;
    assign busy          = (state_q == RUN);
    assign fifo_full     = full_c;

endmodule
